// File: rtl/lc3_pkg.sv
// Shared types and constants for the LC3 writeback block.
//   REG_W/NREGS/RIDX_W : register-file geometry
//   CC_N/CC_Z/CC_P     : bit positions inside a packed {N,Z,P} vector
//   wb_entry_t         : one buffered MEM-stage result
//   nzp_of()           : condition-code vector for a result value
package lc3_pkg;

   localparam int unsigned REG_W  = 16;
   localparam int unsigned NREGS  = 8;
   localparam int unsigned RIDX_W = 3;

   localparam int unsigned CC_N = 2;
   localparam int unsigned CC_Z = 1;
   localparam int unsigned CC_P = 0;
   localparam logic [2:0] CC_RESET = 3'b010;

   typedef struct packed {
      logic [RIDX_W-1:0] dr;
      logic [REG_W-1:0]  data;
      logic              ld_reg;
      logic              ld_cc;
   } wb_entry_t;

   localparam int unsigned ENTRY_W = $bits(wb_entry_t);

   // Exactly one bit set: negative, zero or positive.
   function automatic logic [2:0] nzp_of(input logic [REG_W-1:0] d);
      logic [2:0] r;
      r = '0;
      if (d[REG_W-1]) begin
         r[CC_N] = 1'b1;
      end else if (d == '0) begin
         r[CC_Z] = 1'b1;
      end else begin
         r[CC_P] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/lc3_wb_fifo.sv
// Result FIFO between the MEM stage and the register-file write port.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push_i     : write wdata_i at the tail (ignored when full)
//   pop_i      : drop the head entry (ignored when empty)
//   wdata_i    : packed wb_entry_t
//   head_o     : packed head entry, valid only while !empty_o
//   full_o     : no free slot
//   empty_o    : no stored entry
module lc3_wb_fifo
   import lc3_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic               pop_i,
   input  logic [ENTRY_W-1:0] wdata_i,
   output logic [ENTRY_W-1:0] head_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [ENTRY_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               push_ok, pop_ok;

   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign empty_o = (count_q == '0);
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign head_o  = mem_q[rd_ptr_q];

   // DEPTH is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push_ok && !pop_ok) begin
         count_d = count_q + CNT_W'(1);
      end else if (pop_ok && !push_ok) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage needs no reset: the count gates everything read from it.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

endmodule

// File: rtl/lc3_writeback.sv
// LC3 register-file write port: buffers MEM results, commits one per cycle,
// maintains NZP and a per-register pending-write scoreboard for decode.
//   wb_*      : MEM-stage result channel (valid/ready)
//   rf_hold_i : external owner of the write port, blocks commit
//   rf_*_o    : register-file write interface, driven from the FIFO head
//   cc_*_o    : condition codes
//   dec_*_i   : decode claims and source registers
//   hz*/fwd*  : stall and forward indications for the two sources
//   busy_o    : per-register pending count != 0
//   sb_err_o  : sticky scoreboard over/underflow
module lc3_writeback
   import lc3_pkg::*;
#(
   parameter int unsigned DEPTH  = 2,
   parameter int unsigned PEND_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wb_valid_i,
   output logic              wb_ready_o,
   input  logic [2:0]        wb_dr_i,
   input  logic [15:0]       wb_data_i,
   input  logic              wb_ld_reg_i,
   input  logic              wb_ld_cc_i,
   input  logic              rf_hold_i,
   output logic [15:0]       rf_data_o,
   output logic [2:0]        rf_dr_o,
   output logic              rf_ld_o,
   output logic              cc_n_o,
   output logic              cc_z_o,
   output logic              cc_p_o,
   input  logic              dec_claim_i,
   input  logic [2:0]        dec_claim_dr_i,
   input  logic [2:0]        dec_sr1_i,
   input  logic [2:0]        dec_sr2_i,
   output logic              hz1_o,
   output logic              hz2_o,
   output logic              fwd1_o,
   output logic              fwd2_o,
   output logic [15:0]       fwd_data_o,
   output logic [NREGS-1:0]  busy_o,
   output logic              sb_err_o
);

   localparam logic [PEND_W-1:0] CntMax = '1;
   localparam logic [PEND_W-1:0] CntOne = PEND_W'(1);

   wb_entry_t          in_entry, head;
   logic [ENTRY_W-1:0] head_vec;
   logic               full, empty, commit, retire;

   logic [2:0]         cc_q, cc_d;
   logic [PEND_W-1:0]  cnt_q [NREGS];
   logic [PEND_W-1:0]  cnt_d [NREGS];
   logic               err_q, err_d;
   logic [NREGS-1:0]   claim_vec, retire_vec;

   assign in_entry = '{dr: wb_dr_i, data: wb_data_i, ld_reg: wb_ld_reg_i, ld_cc: wb_ld_cc_i};

   lc3_wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (wb_valid_i),
      .pop_i   (commit),
      .wdata_i (in_entry),
      .head_o  (head_vec),
      .full_o  (full),
      .empty_o (empty)
   );

   assign head       = wb_entry_t'(head_vec);
   assign wb_ready_o = !full;
   assign commit     = !empty && !rf_hold_i;
   assign retire     = commit && head.ld_reg;

   assign rf_data_o  = head.data;
   assign rf_dr_o    = head.dr;
   assign rf_ld_o    = retire;
   assign fwd_data_o = head.data;

   // Condition codes
   assign cc_d   = (commit && head.ld_cc) ? nzp_of(head.data) : cc_q;
   assign cc_n_o = cc_q[CC_N];
   assign cc_z_o = cc_q[CC_Z];
   assign cc_p_o = cc_q[CC_P];

   // Scoreboard
   assign claim_vec  = dec_claim_i ? (NREGS'(1) << dec_claim_dr_i) : '0;
   assign retire_vec = retire ? (NREGS'(1) << head.dr) : '0;

   always_comb begin
      err_d = err_q;
      for (int unsigned r = 0; r < NREGS; r++) begin
         cnt_d[r] = cnt_q[r];
         // A claim and a retire on the same edge cancel out.
         if (claim_vec[r] && !retire_vec[r]) begin
            if (cnt_q[r] == CntMax) begin
               err_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] + CntOne;
            end
         end else if (retire_vec[r] && !claim_vec[r]) begin
            if (cnt_q[r] == '0) begin
               err_d = 1'b1;
            end else begin
               cnt_d[r] = cnt_q[r] - CntOne;
            end
         end
      end
   end

   always_comb begin
      busy_o = '0;
      for (int unsigned r = 0; r < NREGS; r++) begin
         busy_o[r] = (cnt_q[r] != '0);
      end
   end

   assign sb_err_o = err_q;

   // Forwarding only clears the stall when the committing write is the last
   // one outstanding; an older write to the same register is not the value
   // decode needs.
   assign fwd1_o = retire && (head.dr == dec_sr1_i);
   assign fwd2_o = retire && (head.dr == dec_sr2_i);
   assign hz1_o  = busy_o[dec_sr1_i] && !(fwd1_o && cnt_q[dec_sr1_i] == CntOne);
   assign hz2_o  = busy_o[dec_sr2_i] && !(fwd2_o && cnt_q[dec_sr2_i] == CntOne);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cc_q  <= CC_RESET;
         err_q <= 1'b0;
         for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_q[r] <= '0;
         end
      end else begin
         cc_q  <= cc_d;
         err_q <= err_d;
         for (int unsigned r = 0; r < NREGS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

endmodule

// File: tb/tb_lc3_writeback.sv
module tb_lc3_writeback;

   localparam int DEPTH  = 2;
   localparam int PEND_W = 2;
   localparam int PMAX   = (1 << PEND_W) - 1;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wb_valid, wb_ready, wb_ld_reg, wb_ld_cc, rf_hold;
   logic [2:0]  wb_dr, rf_dr, dec_claim_dr, dec_sr1, dec_sr2;
   logic [15:0] wb_data, rf_data, fwd_data;
   logic        rf_ld, cc_n, cc_z, cc_p, dec_claim;
   logic        hz1, hz2, fwd1, fwd2, sb_err;
   logic [7:0]  busy;

   always #5 clk = ~clk;

   lc3_writeback #(
      .DEPTH  (DEPTH),
      .PEND_W (PEND_W)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .wb_valid_i     (wb_valid),
      .wb_ready_o     (wb_ready),
      .wb_dr_i        (wb_dr),
      .wb_data_i      (wb_data),
      .wb_ld_reg_i    (wb_ld_reg),
      .wb_ld_cc_i     (wb_ld_cc),
      .rf_hold_i      (rf_hold),
      .rf_data_o      (rf_data),
      .rf_dr_o        (rf_dr),
      .rf_ld_o        (rf_ld),
      .cc_n_o         (cc_n),
      .cc_z_o         (cc_z),
      .cc_p_o         (cc_p),
      .dec_claim_i    (dec_claim),
      .dec_claim_dr_i (dec_claim_dr),
      .dec_sr1_i      (dec_sr1),
      .dec_sr2_i      (dec_sr2),
      .hz1_o          (hz1),
      .hz2_o          (hz2),
      .fwd1_o         (fwd1),
      .fwd2_o         (fwd2),
      .fwd_data_o     (fwd_data),
      .busy_o         (busy),
      .sb_err_o       (sb_err)
   );

   // ---------------- reference model (monitor-owned) ----------------
   typedef struct {
      logic [2:0]  dr;
      logic [15:0] data;
      logic        ld_reg;
      logic        ld_cc;
   } ent_t;

   ent_t       exp_q[$];
   int         m_cnt[8];
   logic [2:0] m_nzp;     // {N,Z,P}
   logic       m_err;

   int n_chk  = 0;
   int n_pass = 0;
   logic to_flag = 1'b0;

   function automatic logic [2:0] nzp_ref(input logic [15:0] d);
      if ($signed(d) < 0) return 3'b100;
      if (d == 16'd0)     return 3'b010;
      return 3'b001;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_rf_ld", rf_ld, 0);
         chk("rst_busy", busy, 0);
         chk("rst_cc", {cc_n, cc_z, cc_p}, 3'b010);
         chk("rst_ready", wb_ready, 1);
         chk("rst_sb_err", sb_err, 0);
         exp_q.delete();
         foreach (m_cnt[r]) m_cnt[r] = 0;
         m_nzp = 3'b010;
         m_err = 1'b0;
      end else begin
         logic       nonempty, do_commit, e_ld, e_f1, e_f2, e_h1, e_h2;
         logic [7:0] e_busy;
         ent_t       h;
         nonempty  = exp_q.size() > 0;
         do_commit = nonempty && !rf_hold;
         h         = nonempty ? exp_q[0] : '{3'd0, 16'd0, 1'b0, 1'b0};
         e_ld      = do_commit && h.ld_reg;
         foreach (m_cnt[r]) e_busy[r] = (m_cnt[r] != 0);
         e_f1 = e_ld && (h.dr == dec_sr1);
         e_f2 = e_ld && (h.dr == dec_sr2);
         e_h1 = (m_cnt[dec_sr1] > 0) && !(e_f1 && m_cnt[dec_sr1] == 1);
         e_h2 = (m_cnt[dec_sr2] > 0) && !(e_f2 && m_cnt[dec_sr2] == 1);

         chk("timeout", to_flag, 0);
         chk("wb_ready", wb_ready, exp_q.size() < DEPTH);
         chk("rf_ld", rf_ld, e_ld);
         if (nonempty) begin
            chk("rf_data", rf_data, h.data);
            chk("rf_dr", rf_dr, h.dr);
            chk("fwd_data", fwd_data, h.data);
         end
         chk("cc", {cc_n, cc_z, cc_p}, m_nzp);
         chk("busy", busy, e_busy);
         chk("sb_err", sb_err, m_err);
         chk("fwd1", fwd1, e_f1);
         chk("fwd2", fwd2, e_f2);
         chk("hz1", hz1, e_h1);
         chk("hz2", hz2, e_h2);

         // Advance the model across the coming rising edge.
         begin
            logic push;
            push = wb_valid && (exp_q.size() < DEPTH);
            if (do_commit) begin
               void'(exp_q.pop_front());
               if (h.ld_cc) m_nzp = nzp_ref(h.data);
            end
            for (int r = 0; r < 8; r++) begin
               logic inc, dec;
               inc = dec_claim && (dec_claim_dr == 3'(r));
               dec = e_ld && (h.dr == 3'(r));
               if (inc && !dec) begin
                  if (m_cnt[r] == PMAX) m_err = 1'b1;
                  else m_cnt[r]++;
               end else if (dec && !inc) begin
                  if (m_cnt[r] == 0) m_err = 1'b1;
                  else m_cnt[r]--;
               end
            end
            if (push) exp_q.push_back('{wb_dr, wb_data, wb_ld_reg, wb_ld_cc});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wb_valid  = 1'b0;
      dec_claim = 1'b0;
   endtask

   task automatic put(input logic [2:0] dr, input logic [15:0] d, input logic lr,
                      input logic lc, input logic clm);
      wb_valid     = 1'b1;
      wb_dr        = dr;
      wb_data      = d;
      wb_ld_reg    = lr;
      wb_ld_cc     = lc;
      dec_claim    = clm;
      dec_claim_dr = dr;
      step();
      idle();
   endtask

   task automatic claim(input logic [2:0] dr);
      dec_claim    = 1'b1;
      dec_claim_dr = dr;
      step();
      idle();
   endtask

   task automatic mid_reset();
      #2 rst_n = 1'b0;
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      wb_valid = 0; wb_dr = 0; wb_data = 0; wb_ld_reg = 0; wb_ld_cc = 0;
      rf_hold = 0; dec_claim = 0; dec_claim_dr = 0; dec_sr1 = 0; dec_sr2 = 0;
      #12 rst_n = 1'b1;
      step();

      // 1: single result, negative value
      dec_sr1 = 3; dec_sr2 = 0;
      put(3'd3, 16'h8001, 1'b1, 1'b1, 1'b1);
      step(); step();

      // 2: hold fills the FIFO, third result stalls until a slot frees
      rf_hold = 1'b1;
      dec_sr1 = 1; dec_sr2 = 2;
      put(3'd1, 16'h0011, 1'b1, 1'b1, 1'b1);
      put(3'd2, 16'h0022, 1'b1, 1'b1, 1'b1);
      wb_valid = 1'b1; wb_dr = 3'd4; wb_data = 16'h0044; wb_ld_reg = 1; wb_ld_cc = 1;
      step(); step();
      rf_hold = 1'b0;
      begin
         bit done = 0;
         for (int i = 0; i < 10 && !done; i++) begin
            if (wb_ready) begin
               dec_claim = 1'b1; dec_claim_dr = 3'd4;
               done = 1;
            end
            step();
            dec_claim = 1'b0;
         end
         if (!done) to_flag = 1'b1;
      end
      idle();
      step(); step(); step();

      // 3: two claims on R5, two commits; forward only clears the last one
      dec_sr1 = 5; dec_sr2 = 5;
      claim(3'd5);
      claim(3'd5);
      put(3'd5, 16'h0555, 1'b1, 1'b0, 1'b0);
      put(3'd5, 16'h0AAA, 1'b1, 1'b0, 1'b0);
      step(); step();

      // 4: claim R2 on the edge its last pending write commits
      dec_sr1 = 2;
      put(3'd2, 16'h1234, 1'b1, 1'b0, 1'b1);
      claim(3'd2);
      put(3'd2, 16'h4321, 1'b1, 1'b0, 1'b0);
      step(); step();

      // 5: CC-only results
      put(3'd0, 16'h0000, 1'b0, 1'b1, 1'b0);
      put(3'd0, 16'h0004, 1'b0, 1'b1, 1'b0);
      step(); step();

      // 6: async reset with two entries buffered and cnt[1] saturated
      rf_hold = 1'b1;
      claim(3'd1); claim(3'd1); claim(3'd1);
      put(3'd1, 16'h0101, 1'b1, 1'b1, 1'b0);
      put(3'd1, 16'h0202, 1'b1, 1'b1, 1'b0);
      mid_reset();
      rf_hold = 1'b0;
      step();

      // Randomized traffic with periodic mid-cycle resets
      for (int c = 0; c < 2000; c++) begin
         wb_valid  = ($urandom_range(0, 2) != 0);
         wb_dr     = 3'($urandom_range(0, 7));
         case ($urandom_range(0, 5))
            0:       wb_data = 16'h0000;
            1:       wb_data = 16'h8000;
            default: wb_data = 16'($urandom);
         endcase
         wb_ld_reg = ($urandom_range(0, 3) != 0);
         wb_ld_cc  = 1'($urandom);
         rf_hold   = ($urandom_range(0, 3) == 0);
         dec_sr1   = 3'($urandom_range(0, 7));
         dec_sr2   = 3'($urandom_range(0, 7));
         dec_claim    = wb_valid && wb_ready && wb_ld_reg;
         dec_claim_dr = wb_dr;
         if ($urandom_range(0, 63) == 0) begin
            dec_claim    = 1'b1;
            dec_claim_dr = 3'($urandom_range(0, 7));
         end
         if (c % 250 == 249) mid_reset();
         else step();
      end
      idle();
      rf_hold = 1'b0;
      repeat (5) step();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
